// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Sequential multiplier/divider. Shift-add multiply (unsigned or
//            signed, R bits/cycle) and restoring unsigned divide (1 bit/cycle).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int N = 16,
    parameter int R = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_hi,
    output logic [N-1:0] out_lo,
    output logic         err,
    output logic         busy
);

    localparam int c_cnt_w = $clog2(N + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [1:0] c_op_mulu = 2'b00;
    localparam logic [1:0] c_op_muls = 2'b01;
    localparam logic [1:0] c_op_divu = 2'b10;

    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_mul = c_cnt_w'(N / R);
    localparam logic [c_cnt_w-1:0] c_cnt_div = c_cnt_w'(N);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [1:0]         r_op;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2*N-1:0]     r_prod;
    logic [2*N-1:0]     r_mcand;
    logic [N:0]         r_mplier;
    logic               r_neg;
    logic [N-1:0]       r_out_hi;
    logic [N-1:0]       r_out_lo;
    logic               r_err;

    logic               w_accept;
    logic               w_last;
    logic               w_signed;
    logic [N:0]         w_sext_a;
    logic [N:0]         w_sext_b;
    logic [N:0]         w_mag_a;
    logic [N:0]         w_mag_b;
    logic [2*N-1:0]     w_partial;
    logic [2*N-1:0]     w_mul_sum;
    logic [2*N-1:0]     w_mul_res;
    logic [N-1:0]       w_rem;
    logic [N-1:0]       w_quo;
    logic [N+1:0]       w_trial;
    logic               w_ge;
    logic [2*N-1:0]     w_div_next;

    assign in_ready  = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign out_hi    = r_out_hi;
    assign out_lo    = r_out_lo;
    assign err       = r_err;

    assign w_accept = in_valid && (r_state == c_st_idle);
    assign w_last   = (r_state == c_st_run) && (r_cnt == c_cnt_one);

    // Magnitudes are N+1 bits so that -2^(N-1) is representable.
    assign w_signed = (op == c_op_muls);
    assign w_sext_a = {in_a[N-1], in_a};
    assign w_sext_b = {in_b[N-1], in_b};
    assign w_mag_a  = (w_signed && in_a[N-1]) ? (~w_sext_a + {{N{1'b0}}, 1'b1}) : {1'b0, in_a};
    assign w_mag_b  = (w_signed && in_b[N-1]) ? (~w_sext_b + {{N{1'b0}}, 1'b1}) : {1'b0, in_b};

    always_comb begin
        w_partial = '0;
        for (int j = 0; j < R; j++) begin
            if (r_mplier[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    assign w_mul_sum = r_prod + w_partial;
    assign w_mul_res = r_neg ? (~w_mul_sum + {{(2*N-1){1'b0}}, 1'b1}) : w_mul_sum;

    // Restoring step: remainder in the high half, dividend/quotient in the low half.
    assign w_rem      = r_prod[2*N-1:N];
    assign w_quo      = r_prod[N-1:0];
    assign w_trial    = {1'b0, w_rem, w_quo[N-1]} - {2'b00, r_mcand[N-1:0]};
    assign w_ge       = (w_trial[N+1:N] == 2'b00);
    assign w_div_next = {(w_ge ? w_trial[N-1:0] : {w_rem[N-2:0], w_quo[N-1]}),
                         {w_quo[N-2:0], w_ge}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (in_valid)            w_next_state = c_st_run;
            c_st_run:  if (r_cnt == c_cnt_one)  w_next_state = c_st_done;
            c_st_done: if (out_ready)           w_next_state = c_st_idle;
            default:                            w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_out_hi <= '0;
            r_out_lo <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_op     <= op;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            case (op)
                c_op_mulu, c_op_muls: begin
                    r_cnt    <= c_cnt_mul;
                    r_mcand  <= {{(N-1){1'b0}}, w_mag_a};
                    r_mplier <= w_mag_b;
                    r_neg    <= w_signed && (in_a[N-1] ^ in_b[N-1]);
                end
                c_op_divu: begin
                    r_cnt   <= c_cnt_div;
                    r_prod  <= {{N{1'b0}}, in_a};
                    r_mcand <= {{N{1'b0}}, in_b};
                end
                default: r_cnt <= c_cnt_one;
            endcase
        end else if (r_state == c_st_run) begin
            r_cnt <= r_cnt - c_cnt_one;
            case (r_op)
                c_op_mulu, c_op_muls: begin
                    r_prod   <= w_mul_sum;
                    r_mcand  <= r_mcand << R;
                    r_mplier <= r_mplier >> R;
                end
                c_op_divu: r_prod <= w_div_next;
                default: ;
            endcase
            if (w_last) begin
                case (r_op)
                    c_op_mulu, c_op_muls: begin
                        {r_out_hi, r_out_lo} <= w_mul_res;
                        r_err                <= 1'b0;
                    end
                    // A zero divisor naturally yields all-ones quotient and remainder = dividend.
                    c_op_divu: begin
                        {r_out_hi, r_out_lo} <= w_div_next;
                        r_err                <= (r_mcand[N-1:0] == '0);
                    end
                    default: begin
                        r_out_hi <= '0;
                        r_out_lo <= '0;
                        r_err    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
